fetch_npc_stage: RTL and testbench



---
 rtl/fetch_npc_stage.sv | 115 +++++++++++
 tb/tb_fetch_npc_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_npc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_npc_stage
//  Purpose  : MIPS fetch stage. Holds the PC register, selects the next PC
//             (sequential / branch / jump / jr) and loads the F/D pipeline
//             register. The instruction already in F when D resolves a
//             control transfer is the delay slot and is never flushed.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_npc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic        stall,
    input  logic [2:0]  D_npc_op,
    input  logic        D_allow,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_val,
    input  logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic [31:0] D_pc8,
    output logic        redirect,
    output logic        F_fetch_err
);

    localparam logic [2:0] c_OP_SEQ = 3'b000;
    localparam logic [2:0] c_OP_BR  = 3'b001;
    localparam logic [2:0] c_OP_J   = 3'b010;
    localparam logic [2:0] c_OP_JR  = 3'b011;

    logic [31:0] r_f_pc;
    logic [31:0] r_d_pc;
    logic [31:0] r_d_instr;
    logic        r_d_valid;

    logic [2:0]  w_op;
    logic [31:0] w_seq_pc;
    logic [31:0] w_br_pc;
    logic [31:0] w_j_pc;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_fetch_err;

    // An empty D slot (bubble) must never steer fetch, so its op is forced to sequential.
    assign w_op     = r_d_valid ? D_npc_op : c_OP_SEQ;
    assign w_seq_pc = r_f_pc + 32'd4;
    // Branch offset is relative to the delay-slot address (D_pc + 4).
    assign w_br_pc  = r_d_pc + 32'd4 + {{14{D_imm26[15]}}, D_imm26[15:0], 2'b00};
    assign w_j_pc   = {r_d_pc[31:28], D_imm26, 2'b00};

    // Next-PC select; D_allow only matters for conditional branches.
    always_comb begin
        w_next_pc  = w_seq_pc;
        w_redirect = 1'b0;
        case (w_op)
            c_OP_BR: begin
                if (D_allow) begin
                    w_next_pc  = w_br_pc;
                    w_redirect = 1'b1;
                end
            end
            c_OP_J: begin
                w_next_pc  = w_j_pc;
                w_redirect = 1'b1;
            end
            c_OP_JR: begin
                w_next_pc  = D_rs_val;
                w_redirect = 1'b1;
            end
            default: begin
                w_next_pc  = w_seq_pc;
                w_redirect = 1'b0;
            end
        endcase
    end

    // Misaligned or out-of-window fetches are reported, not corrected.
    assign w_fetch_err = (r_f_pc[1:0] != 2'b00) | (r_f_pc < IM_BASE) | (r_f_pc > IM_LIMIT);

    // PC and F/D register: reset > stall > advance; bad fetches enter D as bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f_pc    <= RESET_PC;
            r_d_pc    <= RESET_PC;
            r_d_instr <= 32'd0;
            r_d_valid <= 1'b0;
        end else if (!stall) begin
            r_f_pc <= w_next_pc;
            r_d_pc <= r_f_pc;
            if (w_fetch_err) begin
                r_d_instr <= 32'd0;
                r_d_valid <= 1'b0;
            end else begin
                r_d_instr <= F_instr;
                r_d_valid <= 1'b1;
            end
        end
    end

    assign F_pc        = r_f_pc;
    assign D_pc        = r_d_pc;
    assign D_instr     = r_d_instr;
    assign D_valid     = r_d_valid;
    assign D_pc8       = r_d_pc + 32'd8;
    assign redirect    = w_redirect;
    assign F_fetch_err = w_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_npc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_npc_stage
//  Purpose  : Self-checking bench for fetch_npc_stage against a behavioural
//             model of the PC / F-D register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_npc_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  D_npc_op;
    logic        D_allow;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_val;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic [31:0] D_pc8;
    logic        redirect;
    logic        F_fetch_err;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] m_fpc, m_dpc, m_dinstr;
    logic        m_dvalid;

    fetch_npc_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .D_npc_op    (D_npc_op),
        .D_allow     (D_allow),
        .D_imm26     (D_imm26),
        .D_rs_val    (D_rs_val),
        .F_instr     (F_instr),
        .F_pc        (F_pc),
        .D_pc        (D_pc),
        .D_instr     (D_instr),
        .D_valid     (D_valid),
        .D_pc8       (D_pc8),
        .redirect    (redirect),
        .F_fetch_err (F_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory contents
    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h3000 || a == 32'h3004) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign F_instr = im_word(F_pc);

    function automatic logic ref_err(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    // returns {redirect, next_pc}
    function automatic logic [32:0] ref_next(input logic [2:0] op, input logic allow,
                                             input logic valid, input logic [31:0] dpc,
                                             input logic [25:0] imm, input logic [31:0] rs,
                                             input logic [31:0] fpc);
        int off;
        logic [31:0] tgt;
        if (!valid) return {1'b0, fpc + 32'd4};
        case (op)
            3'd1: begin
                off = int'($signed(imm[15:0]));
                tgt = dpc + 32'd4 + 32'(off * 4);
                if (allow) return {1'b1, tgt};
                return {1'b0, fpc + 32'd4};
            end
            3'd2: return {1'b1, (dpc & 32'hF000_0000) | (32'(imm) << 2)};
            3'd3: return {1'b1, rs};
            default: return {1'b0, fpc + 32'd4};
        endcase
    endfunction

    task automatic model_reset();
        m_fpc = 32'h3000; m_dpc = 32'h3000; m_dinstr = 32'd0; m_dvalid = 1'b0;
    endtask

    // advance one clock, updating the model from the inputs applied now
    task automatic tick();
        logic [32:0] nx;
        logic        err;
        nx  = ref_next(D_npc_op, D_allow, m_dvalid, m_dpc, D_imm26, D_rs_val, m_fpc);
        err = ref_err(m_fpc);
        @(posedge clk); #1;
        if (reset && !stall) begin
            m_dpc    = m_fpc;
            m_dinstr = err ? 32'd0 : im_word(m_fpc);
            m_dvalid = !err;
            m_fpc    = nx[31:0];
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic allow, input logic [25:0] imm,
                         input logic [31:0] rs, input logic st);
        D_npc_op = op; D_allow = allow; D_imm26 = imm; D_rs_val = rs; stall = st;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; D_npc_op = 3'd0; D_allow = 1'b0;
        D_imm26 = 26'd0; D_rs_val = 32'd0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;   // first edge after release is captured by tick() callers
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; D_npc_op = 3'd2; D_allow = 1'b1;
        D_imm26 = 26'h3FFFFFF; D_rs_val = 32'hDEAD_BEEF;
        model_reset();
        #7;
        checks++; if (F_pc !== 32'h3000) begin failures++; $display("FAIL reset_fpc got=%h exp=%h", F_pc, 32'h3000); end
        checks++; if (D_pc !== 32'h3000) begin failures++; $display("FAIL reset_dpc got=%h exp=%h", D_pc, 32'h3000); end
        checks++; if (D_instr !== 32'd0) begin failures++; $display("FAIL reset_dinstr got=%h exp=0", D_instr); end
        checks++; if (D_valid !== 1'b0) begin failures++; $display("FAIL reset_dvalid got=%b exp=0", D_valid); end
        checks++; if (D_pc8 !== 32'h3008) begin failures++; $display("FAIL reset_dpc8 got=%h exp=3008", D_pc8); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0 (D invalid)", redirect); end
        checks++; if (F_fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", F_fetch_err); end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        reset = 1'b1;
        drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0);
        tick();
        checks++; if (F_pc !== 32'h3004) begin failures++; $display("FAIL seq1_fpc got=%h exp=3004", F_pc); end
        checks++; if (D_pc !== 32'h3000 || D_valid !== 1'b1) begin failures++; $display("FAIL seq1_d got=%h/%b exp=3000/1", D_pc, D_valid); end
        checks++; if (D_pc8 !== 32'h3008) begin failures++; $display("FAIL seq1_dpc8 got=%h exp=3008", D_pc8); end
        checks++; if (D_instr !== 32'h2408_0001) begin failures++; $display("FAIL seq1_instr got=%h exp=24080001", D_instr); end
        tick();
        checks++; if (F_pc !== 32'h3008) begin failures++; $display("FAIL seq2_fpc got=%h exp=3008", F_pc); end
        checks++; if (D_instr !== 32'h2408_0001) begin failures++; $display("FAIL seq2_instr got=%h exp=24080001", D_instr); end
    endtask

    task automatic test_branch();
        // D holds 0x3004 after the sequential test
        drive(3'd1, 1'b1, 26'h000FFFF, 32'd0, 1'b0);
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL br_taken_redirect got=%b exp=1", redirect); end
        tick();
        checks++; if (F_pc !== 32'h3004) begin failures++; $display("FAIL br_taken_fpc got=%h exp=3004", F_pc); end
        checks++; if (D_pc !== 32'h3008 || D_valid !== 1'b1) begin failures++; $display("FAIL br_delay_slot got=%h/%b exp=3008/1", D_pc, D_valid); end
        drive(3'd0, 1'b1, 26'd0, 32'd0, 1'b0);
        tick();
        // D at 0x3004 again, not-taken this time
        drive(3'd1, 1'b0, 26'h000FFFF, 32'd0, 1'b0);
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL br_nt_redirect got=%b exp=0", redirect); end
        tick();
        checks++; if (F_pc !== 32'h300C) begin failures++; $display("FAIL br_nt_fpc got=%h exp=300C", F_pc); end
        // allow ignored on non-branch ops
        drive(3'd0, 1'b1, 26'h000FFFF, 32'd0, 1'b0);
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL seq_allow_redirect got=%b exp=0", redirect); end
    endtask

    task automatic test_jal_jr();
        do_reset();
        model_reset();
        m_fpc = 32'h3004; m_dpc = 32'h3000; m_dinstr = im_word(32'h3000); m_dvalid = 1'b1;
        drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (D_pc !== 32'h3010) begin failures++; $display("FAIL jal_setup_dpc got=%h exp=3010", D_pc); end
        drive(3'd2, 1'b0, 26'h0000C10, 32'd0, 1'b0);
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL jal_redirect got=%b exp=1", redirect); end
        tick();
        checks++; if (F_pc !== 32'h3040) begin failures++; $display("FAIL jal_fpc got=%h exp=3040", F_pc); end
        checks++; if (D_pc !== 32'h3014 || D_valid !== 1'b1) begin failures++; $display("FAIL jal_delay got=%h/%b exp=3014/1", D_pc, D_valid); end
        checks++; if (D_pc8 !== 32'h301C) begin failures++; $display("FAIL jal_link got=%h exp=301C", D_pc8); end
        drive(3'd3, 1'b0, 26'd0, 32'h0000_3002, 1'b0);
        tick();
        checks++; if (F_pc !== 32'h3002 || F_fetch_err !== 1'b1) begin failures++; $display("FAIL jr_bad got=%h/%b exp=3002/1", F_pc, F_fetch_err); end
        drive(3'd3, 1'b0, 26'd0, 32'h0000_3000, 1'b0);
        tick();
        checks++; if (D_valid !== 1'b0 || D_instr !== 32'd0) begin failures++; $display("FAIL jr_bubble got=%b/%h exp=0/0", D_valid, D_instr); end
        checks++; if (F_pc !== 32'h3000 || F_fetch_err !== 1'b0) begin failures++; $display("FAIL jr_recover_fpc got=%h/%b exp=3000/0", F_pc, F_fetch_err); end
        // bubble in D must not redirect
        drive(3'd2, 1'b1, 26'h3FFFFFF, 32'd0, 1'b0);
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL bubble_redirect got=%b exp=0", redirect); end
        drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0);
        tick();
        checks++; if (D_valid !== 1'b1 || D_pc !== 32'h3000) begin failures++; $display("FAIL jr_recover_d got=%b/%h exp=1/3000", D_valid, D_pc); end
    endtask

    task automatic test_stall();
        logic [31:0] f0, d0, i0;
        f0 = F_pc; d0 = D_pc; i0 = D_instr;
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 1'b1, 26'h0000010, $urandom, 1'b1);
            checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL stall_redirect got=%b exp=1", redirect); end
            tick();
            checks++; if (F_pc !== f0 || D_pc !== d0 || D_instr !== i0) begin failures++; $display("FAIL stall_hold got=%h/%h/%h exp=%h/%h/%h", F_pc, D_pc, D_instr, f0, d0, i0); end
        end
        drive(3'd1, 1'b1, 26'h0000010, 32'd0, 1'b0);
        tick();
        checks++; if (F_pc !== d0 + 32'h44) begin failures++; $display("FAIL stall_release_fpc got=%h exp=%h", F_pc, d0 + 32'h44); end
        checks++; if (D_pc !== f0) begin failures++; $display("FAIL stall_release_dpc got=%h exp=%h", D_pc, f0); end
    endtask

    task automatic test_random();
        logic [32:0] nx;
        logic [31:0] rs;
        logic [25:0] imm;
        for (int n = 0; n < 400; n++) begin
            if (!m_dvalid && ref_err(m_fpc)) begin
                reset = 1'b0; #1; model_reset(); reset = 1'b1;
            end
            imm = 26'($urandom);
            if ($urandom_range(0, 3) != 0) imm = 26'(($urandom_range(32'h3000, 32'h6FFC) >> 2));
            if ($urandom_range(0, 1) != 0) imm[15:0] = 16'($signed(6'($urandom)));
            rs = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(32'h3000, 32'h6FFC) & ~32'd3);
            drive(3'($urandom), 1'($urandom), imm, rs, ($urandom_range(0, 4) == 0));
            nx = ref_next(D_npc_op, D_allow, m_dvalid, m_dpc, D_imm26, D_rs_val, m_fpc);
            checks++; if (redirect !== nx[32]) begin failures++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, redirect, nx[32]); end
            checks++; if (F_fetch_err !== ref_err(m_fpc)) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, F_fetch_err, ref_err(m_fpc)); end
            tick();
            checks++; if (F_pc !== m_fpc) begin failures++; $display("FAIL rnd_fpc n=%0d got=%h exp=%h", n, F_pc, m_fpc); end
            checks++; if (D_pc !== m_dpc) begin failures++; $display("FAIL rnd_dpc n=%0d got=%h exp=%h", n, D_pc, m_dpc); end
            checks++; if (D_instr !== m_dinstr || D_valid !== m_dvalid) begin failures++; $display("FAIL rnd_d n=%0d got=%h/%b exp=%h/%b", n, D_instr, D_valid, m_dinstr, m_dvalid); end
            checks++; if (D_pc8 !== m_dpc + 32'd8) begin failures++; $display("FAIL rnd_dpc8 n=%0d got=%h exp=%h", n, D_pc8, m_dpc + 32'd8); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        m_fpc = 32'h3004; m_dpc = 32'h3000; m_dinstr = im_word(32'h3000); m_dvalid = 1'b1;
        drive(3'd2, 1'b0, 26'h0001000, 32'd0, 1'b0);
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL ar_pre_redirect got=%b exp=1", redirect); end
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (F_pc !== 32'h3000 || D_pc !== 32'h3000) begin failures++; $display("FAIL ar_pc got=%h/%h exp=3000/3000", F_pc, D_pc); end
        checks++; if (D_valid !== 1'b0 || D_instr !== 32'd0 || redirect !== 1'b0) begin failures++; $display("FAIL ar_d got=%b/%h/%b exp=0/0/0", D_valid, D_instr, redirect); end
        #1;
        reset = 1'b1;
        drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0);
        tick();
        checks++; if (F_pc !== 32'h3004 || D_pc !== 32'h3000 || D_valid !== 1'b1) begin failures++; $display("FAIL ar_first_fetch got=%h/%h/%b exp=3004/3000/1", F_pc, D_pc, D_valid); end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; D_npc_op = 3'd0; D_allow = 1'b0;
        D_imm26 = 26'd0; D_rs_val = 32'd0;
        test_reset();
        test_sequential();
        test_branch();
        test_jal_jr();
        test_stall();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
